fifo_status_monitor: RTL and testbench
======================================

# fifo_status_monitor

Per-FIFO occupancy tracker that drives the status side of the link controller FSM. It counts push/pop strobes for the five data-path FIFOs and produces the `FIFO_EMPTY` and `FIFO_ERROR` vectors consumed by the FSM. It takes the FSM's threshold outputs (`UMF_OUT`, `UVC_OUT`, `UD_OUT`) and returns almost-full and pause indications to the upstream sources. FIFO mapping:

- FIFO 0: main FIFO, uses the UMF threshold.
- FIFOs 1–2: VC FIFOs, use the UVC threshold.
- FIFOs 3–4: D FIFOs, use the UD threshold.

## Interface
Parameters:
- `DEPTH`, 8: entries per FIFO; 2..255.
- `CW`, 4: counter width; must satisfy 2^CW > DEPTH.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. Asserting it clears all state immediately.
- `PUSH` input 5: per-FIFO write strobe, one entry per cycle high.
- `POP` input 5: per-FIFO read strobe, one entry per cycle high.
- `UMF_OUT` input 8: almost-full threshold for FIFO 0.
- `UVC_OUT` input 8: almost-full threshold for FIFOs 1–2.
- `UD_OUT` input 8: almost-full threshold for FIFOs 3–4.
- `FIFO_EMPTY` output 5: count == 0.
- `FIFO_ERROR` output 5: sticky overflow/underflow flag.
- `ALMOST_FULL` output 5: count >= threshold, with threshold nonzero.
- `PAUSE_MAIN` output 1: `ALMOST_FULL[0]`.
- `PAUSE_VC` output 1: `ALMOST_FULL[1] | ALMOST_FULL[2]`.
- `PAUSE_D` output 1: `ALMOST_FULL[3] | ALMOST_FULL[4]`.

## Operation
- Five independent CW-bit counters `cnt[i]`, each range 0..DEPTH.
- All outputs are registered or decoded only from registered state. There are no combinational paths from `PUSH`/`POP` to any output.
- Per-FIFO update on each clock edge, using the count before the edge:
  - Push only, `cnt < DEPTH`: `cnt + 1`.
  - Push only, `cnt == DEPTH`: count unchanged; set `FIFO_ERROR[i]` (overflow).
  - Pop only, `cnt > 0`: `cnt - 1`.
  - Pop only, `cnt == 0`: count unchanged; set `FIFO_ERROR[i]` (underflow).
  - Push + pop, `0 < cnt <= DEPTH`: count unchanged, no error. At full this is a legal pass-through.
  - Push + pop, `cnt == 0`: count becomes 1; set `FIFO_ERROR[i]`, because the pop underflowed.
  - Neither: hold.
- The counter never wraps. Saturation at 0 and at DEPTH is mandatory.
- `FIFO_ERROR[i]` is sticky: once set it stays high until `reset`. There is no other clear path unless `FIFO_STATUS_HWM_EN` is defined (see Configuration).
- Almost-full:
  - `ALMOST_FULL[i] = (thr != 0) && ({8-CW zeros, cnt} >= thr)`, computed as an 8-bit unsigned compare.
  - A threshold of 0 disables the flag. A threshold greater than DEPTH means the flag never asserts.
- Thresholds are sampled every cycle; there is no latching. The FSM guarantees they are stable outside its INIT state. A threshold change takes effect on the next registered `ALMOST_FULL` update.
- No state machine beyond the counters. Each FIFO channel is a saturating up/down counter plus a sticky flag.

## Timing
- Reset values: `cnt = 0`, `FIFO_EMPTY = 5'b11111`, `FIFO_ERROR = 0`, `ALMOST_FULL = 0`, all `PAUSE_* = 0`, `HWM = 0`.
- Latency: a strobe sampled at edge n is reflected in `cnt`, `FIFO_EMPTY` and `FIFO_ERROR` after edge n (1 cycle).
- `ALMOST_FULL` and `PAUSE_*` are registered from the next-state count and current thresholds, so they also update after edge n (1 cycle).
- Reset asserted mid-operation clears everything asynchronously. The first count update happens on the first rising edge after deassertion.

## Configuration
- `FIFO_STATUS_HWM_EN`, when defined, adds:
  - Output `HWM` [5*CW-1:0]: per-FIFO high-water mark, the maximum `cnt` seen since reset, updated 1 cycle after `cnt`.
  - Input `HWM_CLR` [1]: synchronously zeroes all HWM registers and clears all `FIFO_ERROR` bits. If an error event occurs in the same cycle as `HWM_CLR`, the error wins.
- When undefined: neither port exists, and `FIFO_ERROR` is cleared only by `reset`.

## Test plan
- Reset, then 8 pushes to FIFO 0 with `DEPTH = 8`, `UMF_OUT = 6`:
  - `FIFO_EMPTY[0]` falls after the 1st edge.
  - `ALMOST_FULL[0]` and `PAUSE_MAIN` rise after the 6th push.
  - `FIFO_ERROR = 0`.
- Overflow: FIFO 2 full, then one more push:
  - `FIFO_ERROR[2] = 1`, `cnt` stays 8.
  - Then push + pop at full: count stays 8 and no new error.
- Underflow:
  - Pop on empty FIFO 3: `FIFO_ERROR[3] = 1`, `FIFO_EMPTY[3]` stays 1.
  - Separately, push + pop on empty FIFO 4: `FIFO_ERROR[4] = 1`, `FIFO_EMPTY[4] = 0` (count 1).
- Threshold boundaries:
  - `UVC_OUT = 0` with FIFO 1 full: `ALMOST_FULL[1] = 0`, `PAUSE_VC = 0`.
  - `UVC_OUT = 3` with FIFO 1 at 3: `PAUSE_VC = 1`.
  - `UD_OUT = 200`: never asserts.
- Async reset mid-burst (FIFOs at 5/3/1/0/7, errors set): all outputs return to reset values without a clock edge.
- With `FIFO_STATUS_HWM_EN`:
  - Push FIFO 0 to 5, pop to 2: `HWM[CW-1:0] = 5`.
  - `HWM_CLR` pulse: HWM becomes 0 and `FIFO_ERROR` is cleared.

Source files
------------

// File: rtl/fifo_status_monitor.sv
// Occupancy tracker for the five data-path FIFOs: saturating counters, sticky errors, almost-full/pause flags.
// Define FIFO_STATUS_HWM_EN to add per-FIFO high-water marks (HWM) and the HWM_CLR clear strobe.
module fifo_status_monitor #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      PUSH,
  input  logic [4:0]      POP,
  input  logic [7:0]      UMF_OUT,
  input  logic [7:0]      UVC_OUT,
  input  logic [7:0]      UD_OUT,
`ifdef FIFO_STATUS_HWM_EN
  input  logic            HWM_CLR,
  output logic [5*CW-1:0] HWM,
`endif
  output logic [4:0]      FIFO_EMPTY,
  output logic [4:0]      FIFO_ERROR,
  output logic [4:0]      ALMOST_FULL,
  output logic            PAUSE_MAIN,
  output logic            PAUSE_VC,
  output logic            PAUSE_D
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt     [5];
  logic [CW-1:0] cnt_nxt [5];
  logic [7:0]    thr     [5];
  logic [4:0]    err_evt;
  logic [4:0]    af_nxt;
  logic          err_clr;

  assign thr[0] = UMF_OUT;
  assign thr[1] = UVC_OUT;
  assign thr[2] = UVC_OUT;
  assign thr[3] = UD_OUT;
  assign thr[4] = UD_OUT;

`ifdef FIFO_STATUS_HWM_EN
  assign err_clr = HWM_CLR;
`else
  assign err_clr = 1'b0;
`endif

  // Push+pop on an empty FIFO still stores the pushed entry, but the pop underflowed.
  always_comb begin
    err_evt = '0;
    af_nxt  = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_nxt[i] = cnt[i];
      case ({PUSH[i], POP[i]})
        2'b10: begin
          if (cnt[i] == DEPTH_C) err_evt[i] = 1'b1;
          else                   cnt_nxt[i] = cnt[i] + ONE;
        end
        2'b01: begin
          if (cnt[i] == '0) err_evt[i] = 1'b1;
          else              cnt_nxt[i] = cnt[i] - ONE;
        end
        2'b11: begin
          if (cnt[i] == '0) begin
            cnt_nxt[i] = ONE;
            err_evt[i] = 1'b1;
          end
        end
        default: ;
      endcase
      af_nxt[i] = (thr[i] != 8'd0) && (8'(cnt_nxt[i]) >= thr[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
      FIFO_ERROR  <= '0;
      ALMOST_FULL <= '0;
    end else begin
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_nxt[i];
      FIFO_ERROR  <= (FIFO_ERROR & ~{5{err_clr}}) | err_evt;
      ALMOST_FULL <= af_nxt;
    end
  end

  always_comb begin
    FIFO_EMPTY = '0;
    for (int i = 0; i < 5; i++) FIFO_EMPTY[i] = (cnt[i] == '0);
  end

  assign PAUSE_MAIN = ALMOST_FULL[0];
  assign PAUSE_VC   = ALMOST_FULL[1] | ALMOST_FULL[2];
  assign PAUSE_D    = ALMOST_FULL[3] | ALMOST_FULL[4];

`ifdef FIFO_STATUS_HWM_EN
  logic [CW-1:0] hwm [5];

  // Tracks the registered count, so the mark trails the count by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) hwm[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (HWM_CLR)            hwm[i] <= '0;
        else if (cnt[i] > hwm[i]) hwm[i] <= cnt[i];
      end
    end
  end

  always_comb begin
    HWM = '0;
    for (int i = 0; i < 5; i++) HWM[i*CW +: CW] = hwm[i];
  end
`endif

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Bench for fifo_status_monitor: directed scenarios plus random push/pop traffic against a behavioural occupancy model.
module tb_fifo_status_monitor;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      PUSH, POP;
  logic [7:0]      UMF_OUT, UVC_OUT, UD_OUT;
  logic [4:0]      FIFO_EMPTY, FIFO_ERROR, ALMOST_FULL;
  logic            PAUSE_MAIN, PAUSE_VC, PAUSE_D;
  logic            HWM_CLR;
  logic [5*CW-1:0] HWM;

  int checks = 0;
  int errors = 0;

  int   cnt_m [5];
  int   hwm_m [5];
  logic [4:0] err_m;
  logic [4:0] af_m;

  fifo_status_monitor #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .PUSH(PUSH), .POP(POP),
    .UMF_OUT(UMF_OUT), .UVC_OUT(UVC_OUT), .UD_OUT(UD_OUT),
`ifdef FIFO_STATUS_HWM_EN
    .HWM_CLR(HWM_CLR), .HWM(HWM),
`endif
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_ERROR(FIFO_ERROR), .ALMOST_FULL(ALMOST_FULL),
    .PAUSE_MAIN(PAUSE_MAIN), .PAUSE_VC(PAUSE_VC), .PAUSE_D(PAUSE_D)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int thrOf(input int i);
    if (i == 0)      return int'(UMF_OUT);
    else if (i <= 2) return int'(UVC_OUT);
    else             return int'(UD_OUT);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 5; i++) begin
      cnt_m[i] = 0;
      hwm_m[i] = 0;
    end
    err_m = '0;
    af_m  = '0;
  endtask

  task automatic compareAll(input string tag);
    logic [4:0]      exp_empty;
    logic [2:0]      exp_pause;
    logic [5*CW-1:0] exp_hwm;
    for (int i = 0; i < 5; i++) begin
      exp_empty[i]        = (cnt_m[i] == 0);
      exp_hwm[i*CW +: CW] = CW'(hwm_m[i]);
    end
    exp_pause = {af_m[3] | af_m[4], af_m[1] | af_m[2], af_m[0]};
    checkOutput({tag, "_empty"}, 32'(FIFO_EMPTY), 32'(exp_empty));
    checkOutput({tag, "_error"}, 32'(FIFO_ERROR), 32'(err_m));
    checkOutput({tag, "_afull"}, 32'(ALMOST_FULL), 32'(af_m));
    checkOutput({tag, "_pause"}, 32'({PAUSE_D, PAUSE_VC, PAUSE_MAIN}), 32'(exp_pause));
`ifdef FIFO_STATUS_HWM_EN
    checkOutput({tag, "_hwm"}, 32'(HWM), 32'(exp_hwm));
`endif
  endtask

  // One clock of stimulus; the model advances on the edge and outputs are compared on the falling edge.
  task automatic applyStimulus(input logic [4:0] push, input logic [4:0] pop, input logic clr, input string tag);
    PUSH    = push;
    POP     = pop;
    HWM_CLR = clr;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      if (clr) begin
        hwm_m[i] = 0;
        err_m[i] = 1'b0;
      end else if (cnt_m[i] > hwm_m[i]) begin
        hwm_m[i] = cnt_m[i];
      end
      if (push[i] && pop[i]) begin
        if (cnt_m[i] == 0) begin
          cnt_m[i] = 1;
          err_m[i] = 1'b1;
        end
      end else if (push[i]) begin
        if (cnt_m[i] == DEPTH) err_m[i] = 1'b1;
        else                   cnt_m[i]++;
      end else if (pop[i]) begin
        if (cnt_m[i] == 0) err_m[i] = 1'b1;
        else               cnt_m[i]--;
      end
      af_m[i] = (thrOf(i) != 0) && (cnt_m[i] >= thrOf(i));
    end
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    PUSH = '0;
    POP = '0;
    HWM_CLR = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    PUSH = '0;
    POP = '0;
    HWM_CLR = 1'b0;
    UMF_OUT = 8'd0;
    UVC_OUT = 8'd0;
    UD_OUT  = 8'd0;
    modelReset();
    #12;
    compareAll("reset");
    checkOutput("reset_empty_const", 32'(FIFO_EMPTY), 32'h1f);
    @(negedge clk);
    reset = 1'b1;

    // Fill FIFO 0 with the main threshold at 6.
    UMF_OUT = 8'd6;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(5'b00001, 5'b00000, 1'b0, "fill0");
      if (k == 1) checkOutput("empty0_fall", 32'(FIFO_EMPTY[0]), 32'd0);
      if (k == 5) checkOutput("af0_below", 32'(ALMOST_FULL[0]), 32'd0);
      if (k == 6) begin
        checkOutput("af0_at_thr", 32'(ALMOST_FULL[0]), 32'd1);
        checkOutput("pause_main", 32'(PAUSE_MAIN), 32'd1);
      end
    end
    checkOutput("fill0_no_err", 32'(FIFO_ERROR), 32'd0);

    // Overflow on FIFO 2, then a pass-through push+pop at full.
    doReset();
    UVC_OUT = 8'd8;
    for (int k = 0; k < 8; k++) applyStimulus(5'b00100, 5'b00000, 1'b0, "fill2");
    applyStimulus(5'b00100, 5'b00000, 1'b0, "ovf2");
    checkOutput("ovf2_err", 32'(FIFO_ERROR), 32'h04);
    applyStimulus(5'b00100, 5'b00100, 1'b0, "pass2");
    checkOutput("pass2_af", 32'(ALMOST_FULL[2]), 32'd1);
    checkOutput("pass2_err", 32'(FIFO_ERROR), 32'h04);
    for (int k = 0; k < 8; k++) applyStimulus(5'b00000, 5'b00100, 1'b0, "drain2");
    checkOutput("drain2_empty", 32'(FIFO_EMPTY[2]), 32'd1);
    checkOutput("drain2_err", 32'(FIFO_ERROR), 32'h04);

    // Underflow cases on FIFO 3 (pop only) and FIFO 4 (push+pop).
    applyStimulus(5'b00000, 5'b01000, 1'b0, "udf3");
    checkOutput("udf3_err", 32'(FIFO_ERROR[3]), 32'd1);
    checkOutput("udf3_empty", 32'(FIFO_EMPTY[3]), 32'd1);
    applyStimulus(5'b10000, 5'b10000, 1'b0, "udf4");
    checkOutput("udf4_err", 32'(FIFO_ERROR[4]), 32'd1);
    checkOutput("udf4_empty", 32'(FIFO_EMPTY[4]), 32'd0);

    // Threshold boundaries.
    doReset();
    UVC_OUT = 8'd0;
    for (int k = 0; k < 8; k++) applyStimulus(5'b00010, 5'b00000, 1'b0, "thr0");
    checkOutput("thr0_af1", 32'(ALMOST_FULL[1]), 32'd0);
    checkOutput("thr0_pause", 32'(PAUSE_VC), 32'd0);
    UVC_OUT = 8'd3;
    for (int k = 0; k < 5; k++) applyStimulus(5'b00000, 5'b00010, 1'b0, "thr3");
    checkOutput("thr3_pause_at3", 32'(PAUSE_VC), 32'd1);
    applyStimulus(5'b00000, 5'b00010, 1'b0, "thr3b");
    checkOutput("thr3_pause_at2", 32'(PAUSE_VC), 32'd0);
    UD_OUT = 8'd200;
    for (int k = 0; k < 10; k++) applyStimulus(5'b11000, 5'b00000, 1'b0, "thr200");
    checkOutput("thr200_af", 32'(ALMOST_FULL[4:3]), 32'd0);
    checkOutput("thr200_pause", 32'(PAUSE_D), 32'd0);

    // Asynchronous reset with FIFOs at 5/3/1/0/7 and errors pending.
    doReset();
    UMF_OUT = 8'd4;
    UVC_OUT = 8'd2;
    UD_OUT  = 8'd6;
    for (int k = 0; k < 7; k++) begin
      logic [4:0] pv;
      pv = {k < 7, k < 0, k < 1, k < 3, k < 5};
      applyStimulus(pv, 5'b00000, 1'b0, "burst");
    end
    applyStimulus(5'b00000, 5'b01000, 1'b0, "burst_udf");
    checkOutput("burst_pre_af", 32'(ALMOST_FULL), 32'h13);
    #1 reset = 1'b0;
    #1;
    checkOutput("areset_empty", 32'(FIFO_EMPTY), 32'h1f);
    checkOutput("areset_error", 32'(FIFO_ERROR), 32'd0);
    checkOutput("areset_af", 32'(ALMOST_FULL), 32'd0);
    checkOutput("areset_pause", 32'({PAUSE_D, PAUSE_VC, PAUSE_MAIN}), 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic with occasionally changing thresholds.
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) begin
        UMF_OUT = ($urandom_range(0, 7) == 0) ? 8'd200 : 8'($urandom_range(0, 9));
        UVC_OUT = 8'($urandom_range(0, 9));
        UD_OUT  = 8'($urandom_range(0, 9));
      end
      applyStimulus(5'($urandom), 5'($urandom), 1'b0, "rand");
    end

`ifdef FIFO_STATUS_HWM_EN
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(5'b00001, 5'b00000, 1'b0, "hwm_up");
    for (int k = 0; k < 3; k++) applyStimulus(5'b00000, 5'b00001, 1'b0, "hwm_dn");
    checkOutput("hwm0_5", 32'(HWM[CW-1:0]), 32'd5);
    applyStimulus(5'b00000, 5'b00010, 1'b0, "hwm_udf");
    applyStimulus(5'b00000, 5'b00000, 1'b1, "hwm_clr");
    checkOutput("hwm_clr_hwm", 32'(HWM), 32'd0);
    checkOutput("hwm_clr_err", 32'(FIFO_ERROR), 32'd0);
    applyStimulus(5'b00000, 5'b00100, 1'b1, "hwm_clr_err_wins");
    checkOutput("clr_err_wins", 32'(FIFO_ERROR), 32'h04);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
